// File: rtl/msg_source_arbiter.sv
// msg_source_arbiter: round-robin arbiter over N message sources with a
// grant watchdog and an inter-grant gap. Optional per-source grant counters
// are built when the macro ARB_STATS_EN is defined.
module msg_source_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N-1:0]          REQ,
  input  logic [N-1:0]          MASK,
  input  logic                  DONE,
  input  logic                  CLR_STATS,
  output logic [N-1:0]          GRANT,
  output logic [$clog2(N)-1:0]  GRANT_IDX,
  output logic                  GRANT_VALID,
  output logic                  WD_EXPIRED,
  output logic [N*16-1:0]       STATS
);

  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned WDW = 16;
  localparam int unsigned GW  = 4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_grant, w_grant_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_wd_exp, w_wd_exp_nxt;
  logic [WDW-1:0]  r_wd, w_wd_nxt;
  logic [GW-1:0]   r_gap, w_gap_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;

  logic [N-1:0]    w_elig;
  logic            w_win_found;
  logic [IW-1:0]   w_win_idx;
  logic [IW-1:0]   w_cand;
  logic            w_grant_evt;

  assign w_elig = REQ & ~MASK;

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = IW'((32'(r_last) + k) % N);
      if (!w_win_found && w_elig[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_idx_nxt    = r_idx;
    w_valid_nxt  = r_valid;
    w_wd_exp_nxt = 1'b0;
    w_wd_nxt     = r_wd;
    w_gap_nxt    = r_gap;
    w_last_nxt   = r_last;
    w_grant_evt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_state_nxt = S_BUSY;
          w_grant_nxt = N'(1) << w_win_idx;
          w_idx_nxt   = w_win_idx;
          w_valid_nxt = 1'b1;
          w_last_nxt  = w_win_idx;
          w_wd_nxt    = '0;
          w_grant_evt = 1'b1;
        end
      end
      S_BUSY: begin
        if (DONE || (r_wd == WDW'(TIMEOUT_CYC - 1))) begin
          // DONE takes precedence over a simultaneous watchdog expiry.
          w_wd_exp_nxt = !DONE;
          w_state_nxt  = S_GAP;
          w_grant_nxt  = '0;
          w_idx_nxt    = '0;
          w_valid_nxt  = 1'b0;
          w_gap_nxt    = '0;
        end else begin
          w_wd_nxt = r_wd + WDW'(1);
        end
      end
      S_GAP: begin
        if (r_gap == GW'(GAP_CYC - 1)) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_wd_exp <= 1'b0;
      r_wd     <= '0;
      r_gap    <= '0;
      r_last   <= IW'(N - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_idx    <= w_idx_nxt;
      r_valid  <= w_valid_nxt;
      r_wd_exp <= w_wd_exp_nxt;
      r_wd     <= w_wd_nxt;
      r_gap    <= w_gap_nxt;
      r_last   <= w_last_nxt;
    end
  end

  assign GRANT       = r_grant;
  assign GRANT_IDX   = r_idx;
  assign GRANT_VALID = r_valid;
  assign WD_EXPIRED  = r_wd_exp;

`ifdef ARB_STATS_EN
  logic [15:0] r_stats [N];

  // Per-source saturating grant counters; clear wins over increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < N; i++) r_stats[i] <= '0;
    end else if (CLR_STATS) begin
      for (int unsigned i = 0; i < N; i++) r_stats[i] <= '0;
    end else if (w_grant_evt && (r_stats[w_win_idx] != 16'hFFFF)) begin
      r_stats[w_win_idx] <= r_stats[w_win_idx] + 16'd1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_stats
    assign STATS[16*g +: 16] = r_stats[g];
  end
`else
  logic w_unused_stats;
  assign w_unused_stats = CLR_STATS ^ w_grant_evt;
  assign STATS          = '0;
`endif

endmodule

// File: tb/tb_msg_source_arbiter.sv
// Scoreboard bench for msg_source_arbiter: a driver applies stimulus on the
// falling edge, advances a behavioural model and queues the expected outputs;
// a monitor pops and compares after every rising edge.
module tb_msg_source_arbiter;

  localparam int N  = 4;
  localparam int TO = 255;
  localparam int GP = 2;
`ifdef ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  REQ, MASK;
  logic          DONE, CLR_STATS;
  logic [N-1:0]  GRANT;
  logic [1:0]    GRANT_IDX;
  logic          GRANT_VALID, WD_EXPIRED;
  logic [N*16-1:0] STATS;

  msg_source_arbiter #(.N(N), .TIMEOUT_CYC(TO), .GAP_CYC(GP)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .MASK(MASK), .DONE(DONE),
    .CLR_STATS(CLR_STATS), .GRANT(GRANT), .GRANT_IDX(GRANT_IDX),
    .GRANT_VALID(GRANT_VALID), .WD_EXPIRED(WD_EXPIRED), .STATS(STATS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0]    grant;
    logic [1:0]      idx;
    logic            valid;
    logic            wd;
    logic [N*16-1:0] stats;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: who owns the bus, for how long, and the remaining gap.
  int   m_owner;     // -1 when nobody holds a grant
  int   m_age;       // cycles the current grant has been held
  int   m_gap_left;  // idle cycles still owed before arbitration resumes
  int   m_last;
  int   m_cnt [N];
  logic m_wd;

  logic [1:0] seq[$];
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_age = 0; m_gap_left = 0; m_last = N - 1; m_wd = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] req, input logic [N-1:0] mask,
                                     input logic done, input logic clr);
    logic [N-1:0] elig;
    m_wd = 1'b0;
    if (m_owner >= 0) begin
      if (done) begin
        m_owner = -1; m_gap_left = GP;
      end else if (m_age == TO - 1) begin
        m_wd = 1'b1; m_owner = -1; m_gap_left = GP;
      end else begin
        m_age++;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else begin
      elig = req & ~mask;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && elig[c]) begin
          m_owner = c; m_last = c; m_age = 0;
          if (m_cnt[c] < 65535) m_cnt[c]++;
        end
      end
    end
    if (clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.idx   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.valid = (m_owner >= 0);
    e.wd    = m_wd;
    e.stats = '0;
    if (STATS_ON) for (int i = 0; i < N; i++) e.stats[16*i +: 16] = 16'(m_cnt[i]);
    return e;
  endfunction

  task automatic step(input logic [N-1:0] req, input logic [N-1:0] mask,
                      input logic done, input logic clr);
    @(negedge CLK);
    RST = 1'b1; REQ = req; MASK = mask; DONE = done; CLR_STATS = clr;
    model_step(req, mask, done, clr);
    exp_q.push_back(model_out());
  endtask

  // mode 0: fully random; 1: DONE never sent; 2: DONE on the expiry cycle;
  // 3: DONE three cycles into each grant; 4: random MASK, DONE after five.
  task automatic run(input int n, input int mode, input logic [N-1:0] req_f,
                     input logic [N-1:0] mask_f);
    for (int i = 0; i < n; i++) begin
      logic [N-1:0] r, m;
      logic d, c;
      r = req_f; m = mask_f; d = 1'b0; c = 1'b0;
      case (mode)
        0: begin
          r = N'($urandom);
          m = N'($urandom) & N'($urandom);
          d = ($urandom_range(0, 2) == 0);
          c = ($urandom_range(0, 19) == 0);
        end
        2: d = (m_owner >= 0) && (m_age == TO - 1);
        3: d = (m_owner >= 0) && (m_age == 2);
        4: begin
          m = N'($urandom);
          d = (m_owner >= 0) && (m_age == 4);
        end
        default: d = 1'b0;
      endcase
      step(r, m, d, c);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("rst_grant", 64'(GRANT), 64'd0);
    chk("rst_idx",   64'(GRANT_IDX), 64'd0);
    chk("rst_valid", 64'(GRANT_VALID), 64'd0);
    chk("rst_wd",    64'(WD_EXPIRED), 64'd0);
    chk("rst_stats", 64'(STATS), 64'd0);
    model_reset();
    exp_q.push_back(model_out());
  endtask

  // Monitor: compare DUT outputs with the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", 64'(GRANT), 64'(e.grant));
        chk("grant_idx", 64'(GRANT_IDX), 64'(e.idx));
        chk("grant_valid", 64'(GRANT_VALID), 64'(e.valid));
        chk("wd_expired", 64'(WD_EXPIRED), 64'(e.wd));
        chk("stats", 64'(STATS), 64'(e.stats));
      end
      if (GRANT_VALID && !prev_valid) seq.push_back(GRANT_IDX);
      prev_valid = GRANT_VALID;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] want [5];
    RST = 1'b0; REQ = '0; MASK = '0; DONE = 1'b0; CLR_STATS = 1'b0;
    model_reset();
    #3;
    chk("init_valid", 64'(GRANT_VALID), 64'd0);
    chk("init_grant", 64'(GRANT), 64'd0);
    chk("init_stats", 64'(STATS), 64'd0);

    // Empty eligible set and DONE outside BUSY leave the block idle.
    step('0, '0, 1'b1, 1'b0);
    step(4'b0011, 4'b0011, 1'b1, 1'b0);

    // All requesting, DONE three cycles in: rotation 0,1,2,3,0.
    do_reset();
    seq.delete();
    run(32, 3, 4'b1111, 4'b0000);
    want[0] = 2'd0; want[1] = 2'd1; want[2] = 2'd2; want[3] = 2'd3; want[4] = 2'd0;
    chk("rr_count", 64'(seq.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++)
      if (i < seq.size()) chk("rr_order", 64'(seq[i]), 64'(want[i]));

    // Single requester, masked source, mask toggling mid-grant.
    run(12, 3, 4'b0100, 4'b0000);
    run(12, 3, 4'b0011, 4'b0010);
    run(40, 4, 4'b0011, 4'b0000);

    // Watchdog expiry, then DONE coinciding with expiry.
    do_reset();
    run(270, 1, 4'b0100, 4'b0000);
    run(300, 2, 4'b1010, 4'b0000);

    // Five grants to source 2, then clear.
    do_reset();
    run(27, 3, 4'b0100, 4'b0000);
    @(negedge CLK);
    chk("stats_src2", 64'(STATS[47:32]), STATS_ON ? 64'd5 : 64'd0);
    exp_q.push_back(model_out());
    step('0, '0, 1'b0, 1'b1);
    @(negedge CLK);
    chk("stats_clr", 64'(STATS[47:32]), 64'd0);
    exp_q.push_back(model_out());

    // Random traffic with a reset landing mid-grant.
    run(400, 0, '0, '0);
    run(3, 1, 4'b1000, 4'b0000);
    if (m_owner >= 0) chk("pre_rst_valid", 64'(GRANT_VALID), 64'd1);
    do_reset();
    run(400, 0, '0, '0);

    @(negedge CLK);
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
